bcd_updown_multidecade_counter: RTL and testbench

BCD_UPDOWN_MULTIDECADE_COUNTER -- requirements
Module: bcd_updown_multidecade_counter

---
 rtl/bcd_updown_multidecade_counter.sv | 52 +++++
 tb/tb_bcd_updown_multidecade_counter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/bcd_updown_multidecade_counter.sv
// bcd_updown_multidecade_counter: loadable up/down BCD counter; define BCD_SATURATE_EN to hold at terminal instead of wrapping
module bcd_updown_multidecade_counter #(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up_down,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  done,
    output logic                  zero
);
    logic [4*DIGITS-1:0] digits_d, digits_q, load_clamped, stepped;
    logic done_d, done_q, carry, borrow, at_term;
    always_comb begin
        stepped      = digits_q;
        load_clamped = load_value;
        carry        = 1'b1;
        borrow       = 1'b1;
        // carry/borrow ripple: digit k moves only when every lower digit is 9 (up) or 0 (down)
        for (int k = 0; k < DIGITS; k++) begin
            load_clamped[4*k+:4] = (load_value[4*k+:4] > 4'd9) ? 4'd9 : load_value[4*k+:4];
            if (up_down && carry)
                stepped[4*k+:4] = (digits_q[4*k+:4] == 4'd9) ? 4'd0 : digits_q[4*k+:4] + 4'd1;
            if (!up_down && borrow)
                stepped[4*k+:4] = (digits_q[4*k+:4] == 4'd0) ? 4'd9 : digits_q[4*k+:4] - 4'd1;
            carry  = carry && (digits_q[4*k+:4] == 4'd9);
            borrow = borrow && (digits_q[4*k+:4] == 4'd0);
        end
        at_term = up_down ? carry : borrow;
`ifdef BCD_SATURATE_EN
        if (at_term) stepped = digits_q;
`else
`endif
        digits_d = load ? load_clamped : (enable ? stepped : digits_q);
        done_d   = !load && enable && at_term;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            digits_q <= '0;
            done_q   <= 1'b0;
        end else begin
            digits_q <= digits_d;
            done_q   <= done_d;
        end
    end
    assign digits = digits_q;
    assign done   = done_q;
    assign zero   = (digits_q == '0);
endmodule

// File: tb/tb_bcd_updown_multidecade_counter.sv
// tb_bcd_updown_multidecade_counter: scoreboard bench driven by an integer-arithmetic reference model
module tb_bcd_updown_multidecade_counter;
    localparam int DIGITS = 3;
    localparam int W = 4 * DIGITS;
    localparam int MAX = 10 ** DIGITS - 1;

    typedef struct {
        logic [W-1:0] digits;
        logic         done;
        logic         zero;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0, enable = 1'b0, up_down = 1'b0, load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic [W-1:0] digits;
    logic done, zero;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail = 0;
    int cnt = 0;
    bit dn = 1'b0;

    bcd_updown_multidecade_counter #(.DIGITS(DIGITS)) dut (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
        .load_value(load_value), .digits(digits), .done(done), .zero(zero)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k+:4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd_clamped(input logic [W-1:0] b);
        int v, m;
        v = 0;
        m = 1;
        for (int k = 0; k < DIGITS; k++) begin
            v = v + ((b[4*k+:4] > 4'd9) ? 9 : int'(b[4*k+:4])) * m;
            m = m * 10;
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit l, input logic [W-1:0] lv, input bit e, input bit ud);
        exp_t x, got;
        bit term;
        @(negedge clk);
        reset = r; load = l; load_value = lv; enable = e; up_down = ud;
        if (r) begin
            cnt = 0; dn = 1'b0;
        end else if (l) begin
            cnt = from_bcd_clamped(lv); dn = 1'b0;
        end else if (e) begin
            term = ud ? (cnt == MAX) : (cnt == 0);
            dn = term;
            if (term) begin
`ifdef BCD_SATURATE_EN
                cnt = cnt;
`else
                cnt = ud ? 0 : MAX;
`endif
            end else cnt = ud ? cnt + 1 : cnt - 1;
        end else dn = 1'b0;
        x.digits = to_bcd(cnt);
        x.done = dn;
        x.zero = (cnt == 0);
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("digits", 32'(digits), 32'(got.digits));
        check("done", 32'(done), 32'(got.done));
        check("zero", 32'(zero), 32'(got.zero));
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        step(1, 0, '0, 0, 0);
        check("reset_digits", 32'(digits), 32'h0);
        check("reset_zero", 32'(zero), 32'h1);
        for (int i = 0; i < 1000; i++) step(0, 0, '0, 1, 1);
        check("wrap_digits", 32'(digits), 32'h000);
        step(0, 1, W'(12'h099), 0, 1);
        step(0, 0, '0, 1, 1);
        check("up_099", 32'(digits), 32'h100);
        step(0, 0, '0, 1, 0);
        check("down_100", 32'(digits), 32'h099);
        check("down_done", 32'(done), 32'h0);
        step(0, 1, W'(12'h000), 0, 0);
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 0, 0);
        step(0, 1, W'(12'h0FA), 0, 0);
        check("clamp", 32'(digits), 32'h099);
        check("clamp_zero", 32'(zero), 32'h0);
        step(0, 1, W'(12'h457), 0, 0);
        step(1, 1, W'(12'h321), 1, 1);
        check("rst_prio", 32'(digits), 32'h000);
        step(0, 0, '0, 1, 1);
        step(0, 1, W'(12'h998), 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, '0, (i % 2) == 0, 1);
        step(0, 1, W'(12'h999), 0, 1);
        step(0, 0, '0, 1, 1);
        step(0, 0, '0, 1, 0);
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] lv;
            lv = W'($urandom);
            step($urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0, lv,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
